// File: rtl/hack_run_ctrl_if.sv
// Program-load stream and ROM write port of the Hack run controller.
// The master side feeds program words and observes the ROM writes; the slave side is the controller.
interface hack_run_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              load_valid;
    logic [15:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, rom_we, rom_addr, rom_wdata
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, rom_we, rom_addr, rom_wdata
    );
endinterface

// File: rtl/hack_run_ctrl.sv
// Hack computer run controller: streams a program into ROM under CPU reset, then
// sequences hold, free-run, halt, single-step and PC-breakpoint stops.
module hack_run_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int DEPTH       = 32768,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    hack_run_ctrl_if.slave    bus,
    output logic              cpu_reset,
    output logic              cpu_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_HALT = 3'd4,
        S_STEP = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] LAST_PTR  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      HOLD_INIT = 4'(HOLD_CYCLES);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        hold_cnt;
    logic              resume;
    logic              xfer;
    logic              at_end;
    logic              bp_hit;
    logic              enter_load;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [15:0]       wdata_p1;

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] cnt);
        return (cnt >= FULL_CNT) ? FULL_CNT : cnt + 1'b1;
    endfunction

    // A word offered in the same cycle as a restart belongs to neither load and is dropped.
    always_comb begin
        bp_hit     = bp_en && (pc == bp_addr) && !resume;
        xfer       = (state_q == S_LOAD) && bus.load_valid && !load_start;
        at_end     = (word_count == LAST_PTR);
        state_d    = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_start)   state_d = S_LOAD;
                else if (run_req) state_d = S_HOLD;
            end
            S_LOAD: begin
                if (load_start)                               state_d = S_LOAD;
                else if (xfer && (bus.load_last || at_end))   state_d = S_HOLD;
            end
            S_HOLD: begin
                if (load_start)              state_d = S_LOAD;
                else if (hold_cnt <= 4'd1)   state_d = S_RUN;
            end
            S_RUN: begin
                if (load_start)              state_d = S_LOAD;
                else if (halt_req || bp_hit) state_d = S_HALT;
            end
            S_HALT: begin
                if (load_start)    state_d = S_LOAD;
                else if (step_req) state_d = S_STEP;
                else if (run_req)  state_d = S_RUN;
            end
            S_STEP: begin
                if (load_start) state_d = S_LOAD;
                else            state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
        enter_load = (state_d == S_LOAD) && ((state_q != S_LOAD) || load_start);
    end

    // The only combinational output path: a breakpoint match suppresses the commit in RUN.
    assign cpu_en         = (state_q == S_STEP) || ((state_q == S_RUN) && !bp_hit);
    assign bus.load_ready = (state_q == S_LOAD);
    assign state          = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cpu_reset  <= 1'b1;
            hold_cnt   <= 4'd0;
            resume     <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_reset <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_HOLD);
            resume    <= (state_q == S_HALT) && (state_d == S_RUN);

            if ((state_d == S_HOLD) && (state_q != S_HOLD))
                hold_cnt <= HOLD_INIT;
            else if ((state_q == S_HOLD) && (hold_cnt != 4'd0))
                hold_cnt <= hold_cnt - 1'b1;

            if (enter_load) begin
                word_count <= '0;
                overflow   <= 1'b0;
            end else if (xfer) begin
                word_count <= sat_inc(word_count);
                if (!bus.load_last && at_end)
                    overflow <= 1'b1;
            end
        end
    end

    // Stage p1: ROM write lands one cycle after the accepted transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= xfer;
            if (xfer) begin
                addr_p1  <= word_count[ADDR_W-1:0];
                wdata_p1 <= bus.load_data;
            end
        end
    end

    assign bus.rom_we    = vld_p1;
    assign bus.rom_addr  = addr_p1;
    assign bus.rom_wdata = wdata_p1;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Bench for hack_run_ctrl on a 16-word build: directed vector table, multi-cycle
// sequences, and random traffic checked against a cycle-count based reference model.
module tb_hack_run_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int HOLD  = 2;

    logic          clk = 1'b0;
    logic          reset, load_start, run_req, halt_req, step_req, bp_en;
    logic [AW-1:0] pc, bp_addr;
    logic          cpu_reset, cpu_en, overflow;
    logic [2:0]    state;
    logic [AW:0]   word_count;

    hack_run_ctrl_if #(.ADDR_W(AW)) bus ();

    hack_run_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .bus        (bus.slave),
        .cpu_reset  (cpu_reset),
        .cpu_en     (cpu_en),
        .pc         (pc),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .state      (state),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rst, ls, vld;
        logic [15:0] data;
        logic last, run, halt, step, bpe;
        logic [AW-1:0] bpa, pc;
    } vin_t;

    typedef struct packed {
        logic [2:0] st;
        logic crst, en, rdy, we;
        logic [AW-1:0] addr;
        logic [15:0] wd;
        logic [AW:0] wc;
        logic ov;
    } vexp_t;

    typedef struct {
        vin_t  i;
        vexp_t e;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [AW+16-1:0] got_q[$];

    // Every ROM write seen by the bench, as {addr, data}.
    always @(negedge clk) if (bus.rom_we === 1'b1) got_q.push_back({bus.rom_addr, bus.rom_wdata});

    function automatic vin_t mk_in(bit rst, bit ls, bit vld, logic [15:0] data, bit last,
                                   bit run, bit halt, bit step, int p);
        vin_t v;
        v.rst = rst; v.ls = ls; v.vld = vld; v.data = data; v.last = last;
        v.run = run; v.halt = halt; v.step = step; v.bpe = 1'b1;
        v.bpa = AW'(5); v.pc = AW'(p);
        return v;
    endfunction

    function automatic vexp_t mk_ex(int st, bit crst, bit en, bit rdy, bit we, int addr,
                                    logic [15:0] wd, int wc, bit ov);
        vexp_t e;
        e.st = 3'(st); e.crst = crst; e.en = en; e.rdy = rdy; e.we = we;
        e.addr = AW'(addr); e.wd = wd; e.wc = (AW+1)'(wc); e.ov = ov;
        return e;
    endfunction

    function automatic vexp_t observe();
        vexp_t o;
        o.st = state; o.crst = cpu_reset; o.en = cpu_en; o.rdy = bus.load_ready;
        o.we = bus.rom_we; o.addr = bus.rom_addr; o.wd = bus.rom_wdata;
        o.wc = word_count; o.ov = overflow;
        return o;
    endfunction

    task automatic drive(input vin_t v);
        reset = v.rst; load_start = v.ls; bus.load_valid = v.vld; bus.load_data = v.data;
        bus.load_last = v.last; run_req = v.run; halt_req = v.halt; step_req = v.step;
        bp_en = v.bpe; bp_addr = v.bpa; pc = v.pc;
    endtask

    task automatic idle_in();
        vin_t v;
        v = '0;
        drive(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input int idx, input vexp_t e);
        vexp_t g;
        g = observe();
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s[%0d] got st=%0d crst=%0b en=%0b rdy=%0b we=%0b addr=%0d wd=%h wc=%0d ov=%0b, want st=%0d crst=%0b en=%0b rdy=%0b we=%0b addr=%0d wd=%h wc=%0d ov=%0b",
                     name, idx, g.st, g.crst, g.en, g.rdy, g.we, g.addr, g.wd, g.wc, g.ov,
                     e.st, e.crst, e.en, e.rdy, e.we, e.addr, e.wd, e.wc, e.ov);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Reference model state (mode codes follow the state output encoding).
    int m_mode, m_cnt, m_addr, m_run_at, cyc_n;
    bit m_ov, m_we, m_resume, m_crst;
    logic [15:0] m_data;

    function automatic vexp_t model_expect();
        vexp_t e;
        bit hit;
        hit = bp_en && (pc == bp_addr) && !m_resume;
        e = mk_ex(m_mode, m_crst, (m_mode == 5) || (m_mode == 3 && !hit), m_mode == 1,
                  m_we, m_addr, m_data, m_cnt, m_ov);
        return e;
    endfunction

    task automatic model_step();
        int nxt;
        bit hit;
        if (reset) begin
            m_mode = 0; m_crst = 1; m_cnt = 0; m_ov = 0; m_we = 0;
            m_addr = 0; m_data = 0; m_resume = 0;
            return;
        end
        hit = bp_en && (pc == bp_addr) && !m_resume;
        nxt = m_mode;
        m_we = 0;
        case (m_mode)
            0: if (load_start) nxt = 1; else if (run_req) nxt = 2;
            1: begin
                if (load_start) nxt = 1;
                else if (bus.load_valid) begin
                    m_we = 1; m_addr = m_cnt; m_data = bus.load_data;
                    if (bus.load_last) nxt = 2;
                    else if (m_cnt == DEPTH - 1) begin nxt = 2; m_ov = 1; end
                    if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
                end
            end
            2: if (load_start) nxt = 1; else if (cyc_n + 1 == m_run_at) nxt = 3;
            3: if (load_start) nxt = 1; else if (halt_req || hit) nxt = 4;
            4: if (load_start) nxt = 1; else if (step_req) nxt = 5; else if (run_req) nxt = 3;
            default: nxt = load_start ? 1 : 4;
        endcase
        if (load_start) begin m_cnt = 0; m_ov = 0; end
        if (nxt == 2 && m_mode != 2) m_run_at = cyc_n + 1 + HOLD;
        m_resume = (m_mode == 4 && nxt == 3);
        m_crst = (nxt <= 2);
        m_mode = nxt;
    endtask

    vec_t tbl[20];

    initial begin
        int en_cnt;
        vin_t r;

        tbl[0]  = '{mk_in(1,0,0,16'h0000,0,0,0,0,0), mk_ex(0,1,0,0,0,0,16'h0000,0,0)};
        tbl[1]  = '{mk_in(0,1,0,16'h0000,0,0,0,0,0), mk_ex(0,1,0,0,0,0,16'h0000,0,0)};
        tbl[2]  = '{mk_in(0,0,1,16'hA000,0,0,0,0,0), mk_ex(1,1,0,1,0,0,16'h0000,0,0)};
        tbl[3]  = '{mk_in(0,0,1,16'hA001,0,0,0,0,0), mk_ex(1,1,0,1,1,0,16'hA000,1,0)};
        tbl[4]  = '{mk_in(0,0,1,16'hA002,0,0,0,0,0), mk_ex(1,1,0,1,1,1,16'hA001,2,0)};
        tbl[5]  = '{mk_in(0,0,1,16'hA003,1,0,0,0,0), mk_ex(1,1,0,1,1,2,16'hA002,3,0)};
        tbl[6]  = '{mk_in(0,0,0,16'h0000,0,0,0,0,0), mk_ex(2,1,0,0,1,3,16'hA003,4,0)};
        tbl[7]  = '{mk_in(0,0,0,16'h0000,0,0,0,0,0), mk_ex(2,1,0,0,0,3,16'hA003,4,0)};
        tbl[8]  = '{mk_in(0,0,0,16'h0000,0,0,0,0,3), mk_ex(3,0,1,0,0,3,16'hA003,4,0)};
        tbl[9]  = '{mk_in(0,0,0,16'h0000,0,0,0,0,4), mk_ex(3,0,1,0,0,3,16'hA003,4,0)};
        tbl[10] = '{mk_in(0,0,0,16'h0000,0,0,0,0,5), mk_ex(3,0,0,0,0,3,16'hA003,4,0)};
        tbl[11] = '{mk_in(0,0,0,16'h0000,0,1,0,0,5), mk_ex(4,0,0,0,0,3,16'hA003,4,0)};
        tbl[12] = '{mk_in(0,0,0,16'h0000,0,0,0,0,5), mk_ex(3,0,1,0,0,3,16'hA003,4,0)};
        tbl[13] = '{mk_in(0,0,0,16'h0000,0,0,0,0,5), mk_ex(3,0,0,0,0,3,16'hA003,4,0)};
        tbl[14] = '{mk_in(0,0,0,16'h0000,0,1,0,0,6), mk_ex(4,0,0,0,0,3,16'hA003,4,0)};
        tbl[15] = '{mk_in(0,0,0,16'h0000,0,0,1,0,6), mk_ex(3,0,1,0,0,3,16'hA003,4,0)};
        tbl[16] = '{mk_in(0,0,0,16'h0000,0,0,0,1,6), mk_ex(4,0,0,0,0,3,16'hA003,4,0)};
        tbl[17] = '{mk_in(0,0,0,16'h0000,0,0,0,0,5), mk_ex(5,0,1,0,0,3,16'hA003,4,0)};
        tbl[18] = '{mk_in(0,1,0,16'h0000,0,0,0,0,5), mk_ex(4,0,0,0,0,3,16'hA003,4,0)};
        tbl[19] = '{mk_in(0,0,0,16'h0000,0,0,0,0,0), mk_ex(1,1,0,1,0,3,16'hA003,0,0)};

        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(tbl[k].i);
            #1;
            check_vec("table", k, tbl[k].e);
            cyc();
        end

        // Gapped load: only valid cycles write, addresses stay contiguous.
        do_reset();
        load_start = 1'b1; cyc(); load_start = 1'b0;
        got_q.delete();
        for (int k = 0; k < 5; k++) begin
            bus.load_valid = (k % 2 == 0);
            bus.load_data  = 16'hB000 + 16'(k / 2);
            bus.load_last  = (k == 4);
            cyc();
        end
        idle_in();
        chk("gap_state", 32'(state), 32'd2);
        chk("gap_count", 32'(word_count), 32'd3);
        cyc();
        chk("gap_writes", got_q.size(), 3);
        for (int j = 0; j < 3 && j < got_q.size(); j++)
            chk("gap_word", 32'(got_q[j]), 32'({AW'(j), 16'hB000 + 16'(j)}));
        cyc();
        chk("gap_run_state", 32'(state), 32'd3);
        chk("gap_run_crst", 32'(cpu_reset), 32'd0);

        // Load request while running aborts into LOAD.
        load_start = 1'b1; cyc(); load_start = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd1);
        chk("abort_crst", 32'(cpu_reset), 32'd1);
        chk("abort_count", 32'(word_count), 32'd0);

        // Reset in the middle of a load.
        bus.load_valid = 1'b1; bus.load_data = 16'h1234;
        cyc(); cyc();
        chk("midload_count", 32'(word_count), 32'd2);
        reset = 1'b1;
        cyc();
        #1;
        check_vec("reset_in_load", 0, mk_ex(0,1,0,0,0,0,16'h0000,0,0));
        reset = 1'b0;
        idle_in();

        // Overflow: 17 words without a last marker into 16 locations.
        do_reset();
        load_start = 1'b1; cyc(); load_start = 1'b0;
        got_q.delete();
        bus.load_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            bus.load_data = 16'hC000 + 16'(k);
            #1;
            if (k == 16) begin
                chk("ovf_ready17", 32'(bus.load_ready), 32'd0);
                chk("ovf_state", 32'(state), 32'd2);
            end
            cyc();
        end
        idle_in();
        #1;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(word_count), 32'd16);
        chk("ovf_writes", got_q.size(), 16);
        for (int j = 0; j < 16 && j < got_q.size(); j++)
            chk("ovf_word", 32'(got_q[j]), 32'({AW'(j), 16'hC000 + 16'(j)}));

        // Single stepping from HALT, three pulses three cycles apart.
        do_reset();
        run_req = 1'b1; cyc(); run_req = 1'b0;
        chk("step_hold", 32'(state), 32'd2);
        cyc(); cyc();
        chk("step_run", 32'(state), 32'd3);
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        chk("step_halt", 32'(state), 32'd4);
        en_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 3; c++) begin
                step_req = (c == 0);
                #1;
                if (cpu_en) en_cnt++;
                if (c == 1) chk("step_in_step", 32'(state), 32'd5);
                if (c == 2) chk("step_back_halt", 32'(state), 32'd4);
                cyc();
            end
        end
        chk("step_pulses", en_cnt, 3);

        // Random traffic against the reference model.
        do_reset();
        m_mode = 0; m_crst = 1; m_cnt = 0; m_ov = 0; m_we = 0;
        m_addr = 0; m_data = 0; m_resume = 0; m_run_at = 0;
        for (cyc_n = 0; cyc_n < 3000; cyc_n++) begin
            r.rst  = ($urandom_range(0, 299) == 0);
            r.ls   = ($urandom_range(0, 39) == 0);
            r.vld  = $urandom_range(0, 1) == 1;
            r.data = 16'($urandom);
            r.last = ($urandom_range(0, 7) == 0);
            r.run  = ($urandom_range(0, 9) == 0);
            r.halt = ($urandom_range(0, 19) == 0);
            r.step = ($urandom_range(0, 9) == 0);
            r.bpe  = $urandom_range(0, 1) == 1;
            r.bpa  = AW'($urandom_range(0, 3));
            r.pc   = AW'($urandom_range(0, 3));
            drive(r);
            #1;
            check_vec("random", cyc_n, model_expect());
            model_step();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
